// File: rtl/sc_lives_controller.sv
// Lives sequencer for Frogger: turns collision edges into single-cycle upcount
// pulses, runs a respawn window after each hit and declares game over.
module sc_lives_controller #(
   parameter int unsigned DATAWIDTH      = 3,
   parameter int unsigned MAX_LIVES      = 3,
   parameter int unsigned RESPAWN_CYCLES = 25000000,
   parameter int unsigned TIMER_WIDTH    = 25
) (
   input  logic                 SC_LIVES_CONTROLLER_CLOCK_50,
   input  logic                 SC_LIVES_CONTROLLER_RESET_InHigh,
   input  logic                 SC_LIVES_CONTROLLER_start_InLow,
   input  logic                 SC_LIVES_CONTROLLER_collision_InHigh,
   input  logic [DATAWIDTH-1:0] SC_LIVES_CONTROLLER_livesUsed_In,
   output logic                 SC_LIVES_CONTROLLER_upcount_OutLow,
   output logic                 SC_LIVES_CONTROLLER_counterClear_OutHigh,
   output logic                 SC_LIVES_CONTROLLER_playing_OutHigh,
   output logic                 SC_LIVES_CONTROLLER_respawn_OutHigh,
   output logic                 SC_LIVES_CONTROLLER_gameOver_OutHigh,
   output logic [DATAWIDTH-1:0] SC_LIVES_CONTROLLER_livesLeft_Out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PLAYING,
      S_HIT,
      S_SETTLE,
      S_RESPAWN,
      S_GAMEOVER
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(RESPAWN_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);
   localparam logic [DATAWIDTH-1:0]   MAX_L      = DATAWIDTH'(MAX_LIVES);

   state_t                 state_q, state_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic                   start_q, collision_q;
   logic                   upcount_q, clear_q, playing_q, respawn_q, gameover_q;
   logic                   start_edge, hit_edge;

   assign start_edge = ~SC_LIVES_CONTROLLER_start_InLow & start_q;
   assign hit_edge   = SC_LIVES_CONTROLLER_collision_InHigh & ~collision_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE:     if (start_edge) state_d = S_CLEAR;
         S_CLEAR:    state_d = S_PLAYING;
         S_PLAYING:  if (hit_edge) state_d = S_HIT;
         S_HIT:      state_d = S_SETTLE;
         S_SETTLE: begin
            // the counter has absorbed the pulse by now, so the decision sees the new count
            if (SC_LIVES_CONTROLLER_livesUsed_In >= MAX_L) begin
               state_d = S_GAMEOVER;
            end else begin
               state_d = S_RESPAWN;
               timer_d = TIMER_LOAD;
            end
         end
         S_RESPAWN: begin
            if (timer_q == '0) state_d = S_PLAYING;
            else               timer_d = timer_q - TIMER_ONE;
         end
         S_GAMEOVER: if (start_edge) state_d = S_CLEAR;
         default:    state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge SC_LIVES_CONTROLLER_CLOCK_50) begin
      if (SC_LIVES_CONTROLLER_RESET_InHigh) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         start_q     <= 1'b1;
         collision_q <= 1'b0;
         upcount_q   <= 1'b1;
         clear_q     <= 1'b1;
         playing_q   <= 1'b0;
         respawn_q   <= 1'b0;
         gameover_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         start_q     <= SC_LIVES_CONTROLLER_start_InLow;
         collision_q <= SC_LIVES_CONTROLLER_collision_InHigh;
         upcount_q   <= (state_d != S_HIT);
         clear_q     <= (state_d == S_IDLE) || (state_d == S_CLEAR);
         playing_q   <= (state_d == S_PLAYING);
         respawn_q   <= (state_d == S_RESPAWN);
         gameover_q  <= (state_d == S_GAMEOVER);
      end
   end

   assign SC_LIVES_CONTROLLER_upcount_OutLow       = upcount_q;
   assign SC_LIVES_CONTROLLER_counterClear_OutHigh = clear_q;
   assign SC_LIVES_CONTROLLER_playing_OutHigh      = playing_q;
   assign SC_LIVES_CONTROLLER_respawn_OutHigh      = respawn_q;
   assign SC_LIVES_CONTROLLER_gameOver_OutHigh     = gameover_q;

   assign SC_LIVES_CONTROLLER_livesLeft_Out =
      (SC_LIVES_CONTROLLER_livesUsed_In >= MAX_L) ? '0 : MAX_L - SC_LIVES_CONTROLLER_livesUsed_In;

endmodule

// File: tb/tb_sc_lives_controller.sv
// Bench for sc_lives_controller: directed scenarios then random play, checked
// every cycle against a timeline model of a game with an attached lives counter.
module tb_sc_lives_controller;

   localparam int R  = 4;
   localparam int ML = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b1;
   logic       coll = 1'b0;
   logic [2:0] cnt = 3'd0;
   logic [2:0] lives_used;
   logic       up_n, clr, playing, respawn, gover;
   logic [2:0] lives_left;

   bit         corrupt_en = 1'b0;
   logic [2:0] corrupt_val = 3'd0;

   int cmp_cnt  = 0;
   int mism_cnt = 0;

   // reference model: game phase as a timeline counted from the accepted hit
   bit m_idle = 1'b1, m_over = 1'b0, m_clr = 1'b0;
   int m_t = 0;         // 0: no hit in progress, 1: pulse cycle, 2: settle, 3..R+2: respawn
   int m_used = 0;
   bit m_ps = 1'b1, m_pc = 1'b0;

   always #5 clk = ~clk;

   assign lives_used = corrupt_en ? corrupt_val : cnt;

   always @(posedge clk) begin
      if (clr)        cnt <= 3'd0;
      else if (!up_n) cnt <= cnt + 3'd1;
   end

   sc_lives_controller #(
      .DATAWIDTH(3), .MAX_LIVES(ML), .RESPAWN_CYCLES(R), .TIMER_WIDTH(3)
   ) dut (
      .SC_LIVES_CONTROLLER_CLOCK_50            (clk),
      .SC_LIVES_CONTROLLER_RESET_InHigh        (rst),
      .SC_LIVES_CONTROLLER_start_InLow         (start),
      .SC_LIVES_CONTROLLER_collision_InHigh    (coll),
      .SC_LIVES_CONTROLLER_livesUsed_In        (lives_used),
      .SC_LIVES_CONTROLLER_upcount_OutLow      (up_n),
      .SC_LIVES_CONTROLLER_counterClear_OutHigh(clr),
      .SC_LIVES_CONTROLLER_playing_OutHigh     (playing),
      .SC_LIVES_CONTROLLER_respawn_OutHigh     (respawn),
      .SC_LIVES_CONTROLLER_gameOver_OutHigh    (gover),
      .SC_LIVES_CONTROLLER_livesLeft_Out       (lives_left)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mism_cnt++;
         $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic bit m_playing();
      return !m_idle && !m_over && !m_clr && m_t == 0;
   endfunction

   task automatic model_edge(input bit s, input bit c, input bit r);
      bit se, he, old_up, old_clr;
      int seen;
      se      = !s && m_ps;
      he      = c && !m_pc;
      old_up  = (m_t != 1);
      old_clr = m_idle || m_clr;
      seen    = m_used;
      if (old_clr)     m_used = 0;
      else if (!old_up) m_used = (m_used + 1) % 8;
      if (r) begin
         m_idle = 1; m_over = 0; m_clr = 0; m_t = 0; m_ps = 1; m_pc = 0;
         return;
      end
      if (m_idle || m_over) begin
         if (se) begin m_idle = 0; m_over = 0; m_clr = 1; end
      end else if (m_clr) begin
         m_clr = 0;
      end else if (m_t == 2) begin
         if (seen >= ML) begin m_over = 1; m_t = 0; end
         else m_t = 3;
      end else if (m_t == R + 2) begin
         m_t = 0;
      end else if (m_t > 0) begin
         m_t++;
      end else if (he) begin
         m_t = 1;
      end
      m_ps = s;
      m_pc = c;
   endtask

   task automatic check_all();
      int lu, ll;
      lu = corrupt_en ? int'(corrupt_val) : m_used;
      ll = (lu >= ML) ? 0 : ML - lu;
      chk("upcount",   {7'd0, up_n},    {7'd0, (m_t != 1)});
      chk("clear",     {7'd0, clr},     {7'd0, (m_idle || m_clr)});
      chk("playing",   {7'd0, playing}, {7'd0, m_playing()});
      chk("respawn",   {7'd0, respawn}, {7'd0, (m_t >= 3)});
      chk("gameover",  {7'd0, gover},   {7'd0, m_over});
      chk("livesleft", {5'd0, lives_left}, 8'(ll));
      chk("counter",   {5'd0, cnt},     8'(m_used));
   endtask

   task automatic step(input bit s, input bit c, input bit r, input bit do_chk = 1'b1);
      @(negedge clk);
      start = s; coll = c; rst = r;
      @(posedge clk);
      model_edge(s, c, r);
      #1;
      if (do_chk) check_all();
   endtask

   initial begin
      // reset; the counter settles to 0 after the first cleared edge
      step(1, 0, 1, 1'b0);
      step(1, 0, 1);
      step(1, 0, 0);
      // start press: IDLE -> CLEAR -> PLAYING
      step(0, 0, 0);
      step(1, 0, 0);
      repeat (3) step(1, 0, 0);
      // collision held for 10 cycles: one hit, full respawn, no second hit
      repeat (10) step(1, 1, 0);
      repeat (3) step(1, 0, 0);
      // fresh hit, then collision pulses while respawning
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      repeat (3) step(1, 0, 0);
      // hit, then reset on the second respawn cycle
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 0);
      step(1, 0, 0);
      // corrupted counter values seen in IDLE: livesLeft saturates at 0
      corrupt_en = 1'b1;
      for (int v = 0; v < 8; v++) begin
         corrupt_val = 3'(v);
         step(1, 0, 0);
      end
      corrupt_en = 1'b0;
      step(1, 0, 0);
      // new game, three separated hits; start held low across the last hit into game over
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         bit s;
         s = (k == 2) ? 1'b0 : 1'b1;
         step(s, 1, 0);
         repeat (9) step(s, 0, 0);
      end
      repeat (4) step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      repeat (4) step(1, 0, 0);
      // random play
      for (int n = 0; n < 600; n++) begin
         bit rr, ss, cc;
         rr = ($urandom_range(0, 79) == 0);
         ss = ($urandom_range(0, 7) != 0);
         cc = ($urandom_range(0, 3) == 0);
         step(ss, cc, rr);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
      $finish;
   end

endmodule
